// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one step per cycle, followed by a sign-fix cycle and a one-cycle done pulse.
// Divide-by-zero and signed overflow can bypass the iteration (FAST_SPEC=1).
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       count_r;
    logic [2:0]          op_r;
    logic                sign_a_r;
    logic                sign_b_r;
    logic                divzero_r;
    logic [XLEN-1:0]     opnd_r;    // multiplicand for mul, divisor for div
    logic [2*XLEN-1:0]   acc_r;     // mul: {hi,lo} product; div: {remainder, quotient}
    logic                done_r;
    logic [XLEN-1:0]     result_r;

    logic                a_signed_s;
    logic                b_signed_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                divzero_s;
    logic                ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     opnd_init_s;
    logic [2*XLEN-1:0]   acc_init_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       shifted_s;
    logic [XLEN-1:0]     diff_s;
    logic [2*XLEN-1:0]   acc_step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     fix_s;

    // Two's-complement negate, single width
    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negate, double width (full product)
    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Decode the request: operand signedness, magnitudes, special cases, initial datapath state
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3)
            3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            3'b100:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b110:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        sign_a_s  = a_signed_s & srca[XLEN-1];
        sign_b_s  = b_signed_s & srcb[XLEN-1];
        a_mag_s   = sign_a_s ? neg_w(srca) : srca;
        b_mag_s   = sign_b_s ? neg_w(srcb) : srcb;
        divzero_s = funct3[2] & (srcb == {XLEN{1'b0}});
        ovf_s     = funct3[2] & ~funct3[0]
                  & (srca == {1'b1, {(XLEN-1){1'b0}}})
                  & (srcb == {XLEN{1'b1}});
        special_s = divzero_s | ovf_s;
        // The skipped divide-by-zero path preloads the answer the iteration would reach:
        // remainder = dividend magnitude, quotient = all ones. Overflow needs no preload:
        // quotient = |0x80000000| with zero remainder is already correct.
        if (funct3[2]) begin
            opnd_init_s = b_mag_s;
            if (FAST_SPEC && divzero_s) begin
                acc_init_s = {a_mag_s, {XLEN{1'b1}}};
            end else begin
                acc_init_s = {{XLEN{1'b0}}, a_mag_s};
            end
        end else begin
            opnd_init_s = a_mag_s;
            acc_init_s  = {{XLEN{1'b0}}, b_mag_s};
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]}
                   + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        shifted_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        // Only used when shifted_s >= divisor, so the true difference fits in XLEN bits
        diff_s     = shifted_s[XLEN-1:0] - opnd_r;
        acc_step_s = acc_r;
        if (op_r[2]) begin
            if (shifted_s >= {1'b0, opnd_r}) begin
                acc_step_s = {diff_s, acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_step_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign correction and field selection for the final result
    always_comb begin
        prod_s = (sign_a_r ^ sign_b_r) ? neg_d(acc_r) : acc_r;
        quot_s = divzero_r ? {XLEN{1'b1}}
               : ((sign_a_r ^ sign_b_r) ? neg_w(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0]);
        rem_s  = sign_a_r ? neg_w(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            3'b000:                 fix_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_s = quot_s;
            3'b110, 3'b111:         fix_s = rem_s;
            default:                fix_s = {XLEN{1'b0}};
        endcase
    end

    // Pipeline hold: asserted from the accepting cycle through FIX, released in DONE
    always_comb begin
        stall = 1'b0;
        if ((state_r == IDLE) && start && !flush) begin
            stall = 1'b1;
        end else if ((state_r == CALC) || (state_r == FIX)) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Sequencer FSM with registered datapath, done pulse and result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            count_r   <= {CW{1'b0}};
            op_r      <= 3'b000;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            divzero_r <= 1'b0;
            opnd_r    <= {XLEN{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            done_r    <= 1'b0;
            result_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && !flush) begin
                        op_r      <= funct3;
                        sign_a_r  <= sign_a_s;
                        sign_b_r  <= sign_b_s;
                        divzero_r <= divzero_s;
                        opnd_r    <= opnd_init_s;
                        acc_r     <= acc_init_s;
                        count_r   <= {CW{1'b0}};
                        if (FAST_SPEC && special_s) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    done_r <= 1'b0;
                    if (flush) begin
                        state_r <= IDLE;
                    end else begin
                        acc_r   <= acc_step_s;
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        if (count_r == LAST) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        result_r <= fix_s;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes the expected result and
// done cycle, an independent monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] srca = 32'd0;
    logic [31:0] srcb = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] last_res = 32'd0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];

    muldiv_sequencer #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .srca(srca), .srcb(srcb), .flush(flush),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // RV32M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 2;
        if (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 34;
    endfunction

    // Present a request for one cycle (driven at negedge); returns at negedge+1 of N+1
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int n);
        exp_t e;
        @(negedge clk);
        start = 1'b1; flush = 1'b0; funct3 = op; srca = a; srcb = b;
        n = cyc;
        if (push) begin
            e.res = ref_model(op, a, b);
            e.cyc = n + latency(op, a, b);
            e.op  = op;
            exp_q.push_back(e);
        end
        #1 chk("stall_on_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d_pending required=0_pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(posedge clk) begin
        #2;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=result_%h required=no_done", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("result_op%0d", e.op), result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                last_res = e.res;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);

        // 1: mul 7 x -3 with stall window
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1, n);
        chk("stall_calc", {31'd0, stall}, 32'd1);
        for (int k = 2; k <= 33; k++) begin
            @(negedge clk); #1;
            chk("stall_calc", {31'd0, stall}, 32'd1);
        end
        @(negedge clk); #1;
        chk("stall_done", {31'd0, stall}, 32'd0);
        wait_done();

        // 2: high-half multiplies
        issue(3'd1, 32'h80000000, 32'h80000000, 1'b1, n); wait_done();
        issue(3'd3, 32'h80000000, 32'h80000000, 1'b1, n); wait_done();
        issue(3'd2, 32'h80000000, 32'h80000000, 1'b1, n); wait_done();

        // 3: divides and remainders
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1, n); wait_done();
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1, n); wait_done();
        issue(3'd5, 32'd100, 32'd7, 1'b1, n); wait_done();
        issue(3'd7, 32'd100, 32'd7, 1'b1, n); wait_done();

        // 4: fast special cases
        issue(3'd4, 32'd5, 32'd0, 1'b1, n); wait_done();
        issue(3'd6, 32'd5, 32'd0, 1'b1, n); wait_done();
        issue(3'd6, 32'hFFFFFFFB, 32'd0, 1'b1, n); wait_done();
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1, n); wait_done();
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1, n); wait_done();

        // 5: flush mid-multiply, new start the next cycle
        issue(3'd0, 32'd1234, 32'd5678, 1'b0, n);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1 chk("stall_before_flush", {31'd0, stall}, 32'd1);
        issue(3'd5, 32'd1000, 32'd3, 1'b1, n);
        chk("result_kept_after_flush", result, last_res);
        wait_done();

        // flush and start together in IDLE: not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; srca = 32'd3; srcb = 32'd3;
        #1 chk("stall_flush_start", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("stall_not_accepted", {31'd0, stall}, 32'd0);

        // 6: reset mid-divide
        issue(3'd5, 32'hDEADBEEF, 32'd17, 1'b0, n);
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midop_reset_result", result, 32'd0);
        chk("midop_reset_done", {31'd0, done}, 32'd0);
        chk("midop_reset_stall", {31'd0, stall}, 32'd0);
        last_res = 32'd0;

        // start during CALC is ignored
        issue(3'd5, 32'hDEADBEEF, 32'd17, 1'b1, n);
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'd0; srca = 32'd9; srcb = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // randomized back-to-back operations
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, 1'b1, n);
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
